// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: scheduler states, segment constants and the digit glyph table.
// Patterns are {a,b,c,d,e,f,g,dp}, active-high.
package seg_pkg;

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_BANNER  = 2'd1,
        S_MILEAGE = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h02;
    localparam logic [7:0] SEG_DP    = 8'h01;

    // Any code above 9 renders as a dash; this one is used explicitly for banner dashes.
    localparam logic [3:0] CODE_DASH = 4'hF;

    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
        8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6
    };

    function automatic logic [7:0] digit_pattern(input logic [3:0] code);
        logic [7:0] pattern;
        pattern = SEG_DASH;
        if (code <= 4'd9) begin
            pattern = SEG_DIGIT[code];
        end
        return pattern;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational glyph decoder: BCD code plus blank/dp flags to one digit's segment pattern.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = blank ? SEG_BLANK : digit_pattern(code);
        if (dp) begin
            pattern = pattern | SEG_DP;
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Drives the 8-digit display: scans four slots (digit i and i+4 together) and chooses
// between blank, a mode banner and a frame-stable mileage snapshot.
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int SCAN_DIV      = 100000,
    parameter int BANNER_FRAMES = 500,
    parameter int DP_POS        = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [31:0] mileage_bcd,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1
);

    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TIMER_W = $clog2(BANNER_FRAMES + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(BANNER_FRAMES);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    logic [PRESC_W-1:0] prescaler;
    logic               tick;
    logic [1:0]         scan_idx;
    logic [1:0]         idx_next;
    logic               frame_end;
    logic [1:0]         mode_q;
    logic               mode_change;
    logic [31:0]        snapshot;
    logic [31:0]        disp_bcd;
    logic [TIMER_W-1:0] banner_timer;
    logic [TIMER_W-1:0] timer_next;
    state_t             state;
    state_t             state_next;

    logic [3:0]         dig_code [8];
    logic [7:0]         dig_blank;
    logic [7:0]         dig_dp;
    logic               lead_zero;
    logic [3:0]         nib;

    logic [2:0]         sel0;
    logic [2:0]         sel1;
    logic [3:0]         dec0_code;
    logic [3:0]         dec1_code;
    logic               dec0_blank;
    logic               dec1_blank;
    logic               dec0_dp;
    logic               dec1_dp;
    logic [7:0]         pattern0;
    logic [7:0]         pattern1;
    logic [7:0]         en_next;

    assign tick      = (prescaler == PRESC_LAST);
    assign idx_next  = scan_idx + 2'd1;
    assign frame_end = tick && (scan_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            scan_idx  <= 2'd0;
        end else if (tick) begin
            prescaler <= '0;
            scan_idx  <= idx_next;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // The snapshot only moves at frame end, so a frame never mixes two mileage values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 2'b00;
            snapshot <= '0;
        end else begin
            mode_q <= mode;
            if (frame_end) begin
                snapshot <= mileage_bcd;
            end
        end
    end

    // Slot 0 of a new frame is loaded on the same edge the snapshot updates, so use the incoming value.
    assign disp_bcd    = frame_end ? mileage_bcd : snapshot;
    assign mode_change = (mode != mode_q) && (mode != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_OFF;
            banner_timer <= '0;
        end else begin
            state        <= state_next;
            banner_timer <= timer_next;
        end
    end

    // A mode change takes priority over an expiring banner on the same frame end.
    always_comb begin
        state_next = state;
        timer_next = banner_timer;
        if (mode == 2'b00) begin
            state_next = S_OFF;
            timer_next = '0;
        end else begin
            case (state)
                S_OFF: begin
                    state_next = S_BANNER;
                    timer_next = TIMER_LOAD;
                end
                S_BANNER: begin
                    if (mode_change) begin
                        timer_next = TIMER_LOAD;
                    end else if (frame_end) begin
                        if (banner_timer <= TIMER_ONE) begin
                            state_next = S_MILEAGE;
                            timer_next = '0;
                        end else begin
                            timer_next = banner_timer - 1'b1;
                        end
                    end
                end
                S_MILEAGE: begin
                    if (mode_change) begin
                        state_next = S_BANNER;
                        timer_next = TIMER_LOAD;
                    end
                end
                default: begin
                    state_next = S_OFF;
                    timer_next = '0;
                end
            endcase
        end
    end

    // Per-digit content; leading-zero suppression stops at the dp digit so it always shows.
    always_comb begin
        lead_zero = 1'b1;
        nib       = '0;
        dig_blank = '1;
        dig_dp    = '0;
        for (int d = 0; d < 8; d++) begin
            nib         = disp_bcd[31-4*d -: 4];
            lead_zero   = lead_zero && (nib == 4'd0);
            dig_code[d] = nib;
            if (state == S_MILEAGE) begin
                dig_blank[d] = (d < DP_POS) && lead_zero;
                dig_dp[d]    = (d == DP_POS);
            end else if (state == S_BANNER) begin
                if (d == 2 || d == 4) begin
                    dig_code[d]  = CODE_DASH;
                    dig_blank[d] = 1'b0;
                end else if (d == 3) begin
                    dig_code[d]  = {2'b00, mode_q};
                    dig_blank[d] = 1'b0;
                end
            end
        end
    end

    assign sel0       = {1'b0, idx_next};
    assign sel1       = {1'b1, idx_next};
    assign dec0_code  = dig_code[sel0];
    assign dec1_code  = dig_code[sel1];
    assign dec0_blank = dig_blank[sel0];
    assign dec1_blank = dig_blank[sel1];
    assign dec0_dp    = dig_dp[sel0];
    assign dec1_dp    = dig_dp[sel1];

    seg_decoder u_dec_left (
        .code    (dec0_code),
        .blank   (dec0_blank),
        .dp      (dec0_dp),
        .pattern (pattern0)
    );

    seg_decoder u_dec_right (
        .code    (dec1_code),
        .blank   (dec1_blank),
        .dp      (dec1_dp),
        .pattern (pattern1)
    );

    always_comb begin
        en_next       = '0;
        en_next[sel0] = 1'b1;
        en_next[sel1] = 1'b1;
    end

    // Blanking in S_OFF is immediate; otherwise the pins only change on a scan tick.
    always_ff @(posedge clk) begin
        if (rst || state == S_OFF) begin
            seg_en <= '0;
            seg0   <= '0;
            seg1   <= '0;
        end else if (tick) begin
            seg_en <= en_next;
            seg0   <= pattern0;
            seg1   <= pattern1;
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with a fast scan: banner, mileage view,
// frame-stable snapshots, mode changes and reset behaviour.
module tb_seg_display_scheduler;

    localparam logic [7:0] P_BLK  = 8'h00;
    localparam logic [7:0] P_DASH = 8'h02;
    localparam logic [7:0] P_0    = 8'hFC;
    localparam logic [7:0] P_0DP  = 8'hFD;
    localparam logic [7:0] P_1    = 8'h60;
    localparam logic [7:0] P_2    = 8'hDA;
    localparam logic [7:0] P_3    = 8'hF2;
    localparam logic [7:0] P_3DP  = 8'hF3;
    localparam logic [7:0] P_4    = 8'h66;
    localparam logic [7:0] P_5    = 8'hB6;
    localparam logic [7:0] P_7    = 8'hE0;
    localparam logic [7:0] P_9    = 8'hF6;
    localparam logic [7:0] P_9DP  = 8'hF7;

    localparam logic [31:0] BCD_A = 32'h0001_2345;
    localparam logic [31:0] BCD_B = 32'h0B00_7000;
    localparam logic [31:0] BCD_Z = 32'h0000_0000;
    localparam logic [31:0] BCD_9 = 32'h9999_9999;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] bcd;
        logic [7:0]  en;
        logic [7:0]  s0;
        logic [7:0]  s1;
        int          budget;
    } vec_t;

    localparam int NVEC = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [31:0] mileage_bcd;
    logic [7:0]  seg_en;
    logic [7:0]  seg0;
    logic [7:0]  seg1;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NVEC];

    seg_display_scheduler #(
        .SCAN_DIV      (2),
        .BANNER_FRAMES (3),
        .DP_POS        (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .mileage_bcd (mileage_bcd),
        .seg_en      (seg_en),
        .seg0        (seg0),
        .seg1        (seg1)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic check_blank(input string name);
        check_output({name, " seg_en"}, seg_en, 8'h00);
        check_output({name, " seg0"}, seg0, 8'h00);
        check_output({name, " seg1"}, seg1, 8'h00);
    endtask

    task automatic wait_slot(input logic [7:0] en, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (seg_en === en) break;
        end
    endtask

    task automatic apply_stimulus(input int i);
        mode        = vecs[i].mode;
        mileage_bcd = vecs[i].bcd;
        wait_slot(vecs[i].en, vecs[i].budget);
        check_output($sformatf("vec%0d seg_en", i), seg_en, vecs[i].en);
        check_output($sformatf("vec%0d seg0", i), seg0, vecs[i].s0);
        check_output($sformatf("vec%0d seg1", i), seg1, vecs[i].s1);
    endtask

    // Counts banner frame starts (slot 0 showing a dash on digit 4) until mileage appears.
    task automatic count_banner(input logic [7:0] numeral, input logic [7:0] mileage_seg1);
        int         banners;
        bit         done;
        bit         saw_num;
        logic [7:0] num_val;
        logic [7:0] prev;
        banners = 0;
        done    = 1'b0;
        saw_num = 1'b0;
        num_val = 8'h00;
        prev    = seg_en;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (seg_en !== prev) begin
                if (seg_en == 8'h88 && !saw_num) begin
                    saw_num = 1'b1;
                    num_val = seg0;
                end
                if (seg_en == 8'h11) begin
                    if (seg1 == P_DASH) banners++;
                    else done = 1'b1;
                end
            end
            prev = seg_en;
        end
        check_output("banner numeral", num_val, numeral);
        check_output("banner frame count", 8'(banners), 8'd3);
        check_output("mileage after banner", seg1, mileage_seg1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{2'b01, BCD_A, 8'h44, P_DASH, P_BLK, 12};
        vecs[1]  = '{2'b01, BCD_A, 8'h88, P_1, P_BLK, 4};
        vecs[2]  = '{2'b01, BCD_A, 8'h11, P_BLK, P_DASH, 4};
        vecs[3]  = '{2'b01, BCD_A, 8'h22, P_BLK, P_BLK, 4};
        vecs[4]  = '{2'b11, BCD_A, 8'h22, P_BLK, P_3DP, 4};
        vecs[5]  = '{2'b11, BCD_A, 8'h44, P_BLK, P_4, 4};
        vecs[6]  = '{2'b11, BCD_A, 8'h88, P_1, P_5, 4};
        vecs[7]  = '{2'b11, BCD_A, 8'h11, P_BLK, P_2, 4};
        vecs[8]  = '{2'b11, BCD_B, 8'h22, P_BLK, P_3DP, 4};
        vecs[9]  = '{2'b11, BCD_B, 8'h44, P_BLK, P_4, 4};
        vecs[10] = '{2'b11, BCD_B, 8'h88, P_1, P_5, 4};
        vecs[11] = '{2'b11, BCD_B, 8'h11, P_BLK, P_7, 4};
        vecs[12] = '{2'b11, BCD_B, 8'h22, P_DASH, P_0DP, 4};
        vecs[13] = '{2'b11, BCD_B, 8'h44, P_0, P_0, 4};
        vecs[14] = '{2'b11, BCD_B, 8'h88, P_0, P_0, 4};
        vecs[15] = '{2'b11, BCD_B, 8'h11, P_BLK, P_7, 4};
        vecs[16] = '{2'b11, BCD_Z, 8'h22, P_DASH, P_0DP, 4};
        vecs[17] = '{2'b11, BCD_Z, 8'h44, P_0, P_0, 4};
        vecs[18] = '{2'b11, BCD_Z, 8'h88, P_0, P_0, 4};
        vecs[19] = '{2'b11, BCD_Z, 8'h11, P_BLK, P_BLK, 4};
        vecs[20] = '{2'b11, BCD_Z, 8'h22, P_BLK, P_0DP, 4};
        vecs[21] = '{2'b11, BCD_Z, 8'h44, P_BLK, P_0, 4};
        vecs[22] = '{2'b11, BCD_Z, 8'h88, P_BLK, P_0, 4};
        vecs[23] = '{2'b11, BCD_9, 8'h11, P_9, P_9, 4};
        vecs[24] = '{2'b11, BCD_9, 8'h22, P_9, P_9DP, 4};

        rst         = 1'b1;
        mode        = 2'b00;
        mileage_bcd = BCD_A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_blank($sformatf("reset cycle %0d", i));
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_output($sformatf("idle seg_en %0d", i), seg_en, 8'h00);
        end
        check_blank("idle end");

        // Banner for mode 1, then a switch to mode 3 while the banner is still up.
        for (int i = 0; i < 4; i++) apply_stimulus(i);
        wait_slot(8'h44, 4);
        check_output("pre-change slot", seg_en, 8'h44);
        mode = 2'b11;
        count_banner(P_3, P_2);

        for (int i = 4; i < NVEC; i++) apply_stimulus(i);

        // Mode off in the middle of a slot.
        wait_slot(8'h44, 4);
        mode = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check_blank("mode off");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output($sformatf("off seg_en %0d", i), seg_en, 8'h00);
        end

        // Reset in the middle of a banner frame, then restart in mode 2.
        mode = 2'b01;
        wait_slot(8'h22, 14);
        check_output("pre-reset slot", seg_en, 8'h22);
        rst = 1'b1;
        @(negedge clk);
        check_blank("mid-frame reset");
        mode = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check_blank("post-reset idle");
        mode = 2'b10;
        wait_slot(8'h44, 12);
        check_output("restart seg_en", seg_en, 8'h44);
        check_output("restart dash", seg0, P_DASH);
        wait_slot(8'h88, 4);
        check_output("restart numeral", seg0, P_2);
        check_output("restart digit7", seg1, P_BLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
